// File: rtl/inst_fetch.sv
// Instruction fetch stage: single-outstanding-request bus master feeding one
// instruction at a time to decode, with delay-slot jump handling and exception redirect.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_ready,
    input  logic        is_jump,
    input  logic [31:0] jump_pc,
    input  logic        exc_en,
    input  logic [31:0] exc_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] next_pc,
    output logic        fetch_err,
    output logic [31:0] err_addr
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_VALID = 2'd1,
        S_DRAIN = 2'd2,
        S_ERR   = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        pending_q, pending_d;
    logic [31:0] pending_pc_q, pending_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic        fetch_err_q, fetch_err_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic        aligned;
    logic        handover;
    logic [31:0] fetch_pc_inc;

    assign aligned      = (fetch_pc_q[1:0] == 2'b00);
    assign handover     = inst_valid_q && id_ready;
    assign fetch_pc_inc = fetch_pc_q + 32'd4;

    // Gated by rst_n so no request leaks out while reset is held.
    assign mem_req    = rst_n && (state_q == S_REQ) && aligned;
    assign mem_addr   = fetch_pc_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign next_pc    = next_pc_q;
    assign fetch_err  = fetch_err_q;
    assign err_addr   = err_addr_q;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_d    = pending_q;
        pending_pc_d = pending_pc_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        next_pc_d    = next_pc_q;
        fetch_err_d  = fetch_err_q;
        err_addr_d   = err_addr_q;

        case (state_q)
            S_REQ: begin
                if (exc_en) begin
                    // An issued but unacked request must be drained before refetching.
                    state_d = (aligned && !mem_ack) ? S_DRAIN : S_REQ;
                end else if (!aligned) begin
                    fetch_err_d = 1'b1;
                    err_addr_d  = fetch_pc_q;
                    state_d     = S_ERR;
                end else if (mem_ack) begin
                    inst_d       = mem_rdata;
                    next_pc_d    = fetch_pc_inc;
                    inst_valid_d = 1'b1;
                    state_d      = S_VALID;
                    fetch_pc_d   = pending_q ? pending_pc_q : fetch_pc_inc;
                    pending_d    = 1'b0;
                end
            end
            S_VALID: begin
                if (exc_en) begin
                    state_d = S_REQ;
                end else if (handover) begin
                    inst_valid_d = 1'b0;
                    state_d      = S_REQ;
                    if (is_jump) begin
                        pending_d    = 1'b1;
                        pending_pc_d = jump_pc;
                    end
                end
            end
            S_DRAIN: begin
                if (mem_ack) begin
                    state_d = S_REQ;
                end
            end
            S_ERR: begin
                if (exc_en) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // Redirect wins over everything else computed above.
        if (exc_en) begin
            fetch_pc_d   = exc_pc;
            pending_d    = 1'b0;
            inst_valid_d = 1'b0;
            fetch_err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            fetch_pc_q   <= RESET_PC;
            pending_q    <= 1'b0;
            pending_pc_q <= 32'd0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'd0;
            next_pc_q    <= 32'd0;
            fetch_err_q  <= 1'b0;
            err_addr_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            next_pc_q    <= next_pc_d;
            fetch_err_q  <= fetch_err_d;
            err_addr_q   <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios followed by a randomized run against
// a transaction-level model of fetch order, delay slots and exception redirects.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_ready = 1'b0;
    logic        is_jump = 1'b0;
    logic [31:0] jump_pc = 32'd0;
    logic        exc_en = 1'b0;
    logic [31:0] exc_pc = 32'd0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] next_pc;
    logic        fetch_err;
    logic [31:0] err_addr;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] RPC = 32'hBFC00000;

    inst_fetch #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .id_ready(id_ready), .is_jump(is_jump),
        .jump_pc(jump_pc), .exc_en(exc_en), .exc_pc(exc_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .inst_valid(inst_valid), .inst(inst),
        .next_pc(next_pc), .fetch_err(fetch_err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        mem_ack  = 1'b0;
        id_ready = 1'b0;
        is_jump  = 1'b0;
        exc_en   = 1'b0;
    endtask

    // Reset asserted mid-cycle; any outstanding request is dropped immediately.
    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        #1;
        chk("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, RPC);
        chk("rst_vld", inst_valid, 1'b0);
        @(negedge clk);
        chk("rst_inst", inst, 32'd0);
        chk("rst_npc", next_pc, 32'd0);
        chk("rst_err", fetch_err, 1'b0);
        chk("rst_eaddr", err_addr, 32'd0);
        rst_n = 1'b1;
    endtask

    // One fetch with zero-wait ack, optional decode stall, then handover.
    task automatic fetch_one(input logic [31:0] a, input logic [31:0] d,
                             input logic j, input logic [31:0] jpc, input int stall);
        @(negedge clk);
        clear_inputs();
        chk("f_req", mem_req, 1'b1);
        chk("f_addr", mem_addr, a);
        chk("f_err", fetch_err, 1'b0);
        chk("f_vld0", inst_valid, 1'b0);
        mem_ack   = 1'b1;
        mem_rdata = d;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            chk("stall_vld", inst_valid, 1'b1);
            chk("stall_inst", inst, d);
            chk("stall_req", mem_req, 1'b0);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        chk("f_vld", inst_valid, 1'b1);
        chk("f_inst", inst, d);
        chk("f_npc", next_pc, a + 32'd4);
        chk("f_req_hold", mem_req, 1'b0);
        id_ready = 1'b1;
        is_jump  = j;
        jump_pc  = jpc;
    endtask

    // Random-phase model state
    logic [31:0] exp_fetch, exp_inst, exp_next, pend_pc, r, p;
    logic        exp_valid, exp_drain, pend;
    logic        do_exc, do_ack;

    initial begin
        do_reset();
        // Sequential fetch from reset vector
        fetch_one(RPC,           32'h11111111, 1'b0, 32'd0, 0);
        fetch_one(RPC + 32'd4,   32'h22222222, 1'b0, 32'd0, 0);
        fetch_one(RPC + 32'd8,   32'h33333333, 1'b0, 32'd0, 0);

        // Jump with one delay slot
        do_reset();
        fetch_one(RPC,           32'h0BF00040, 1'b1, 32'h80000100, 0);
        fetch_one(RPC + 32'd4,   32'h00000000, 1'b0, 32'd0, 0);
        fetch_one(32'h80000100,  32'hA0000001, 1'b0, 32'd0, 0);
        fetch_one(32'h80000104,  32'hA0000002, 1'b0, 32'd0, 0);

        // Decode stall for 5 cycles
        fetch_one(32'h80000108,  32'h24020001, 1'b0, 32'd0, 5);

        // Exception while request outstanding, redirected again during drain
        @(negedge clk);
        clear_inputs();
        chk("exc_req", mem_req, 1'b1);
        chk("exc_addr", mem_addr, 32'h8000010C);
        exc_en = 1'b1;
        exc_pc = 32'h80000200;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            clear_inputs();
            chk("drain_req", mem_req, 1'b0);
            chk("drain_vld", inst_valid, 1'b0);
            if (k == 1) begin
                exc_en = 1'b1;
                exc_pc = 32'h80000180;
            end
            if (k == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEADBEEF;
            end
        end
        // Jump to a misaligned target
        fetch_one(32'h80000180,  32'hB0000001, 1'b1, 32'h80000102, 0);
        fetch_one(32'h80000184,  32'hB0000002, 1'b0, 32'd0, 0);
        @(negedge clk);
        clear_inputs();
        chk("mis_req", mem_req, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("err_flag", fetch_err, 1'b1);
            chk("err_addr", err_addr, 32'h80000102);
            chk("err_req", mem_req, 1'b0);
        end
        exc_en = 1'b1;
        exc_pc = 32'hFFFFFFFC;
        // Address wrap
        fetch_one(32'hFFFFFFFC,  32'hC0000001, 1'b0, 32'd0, 0);
        fetch_one(32'h00000000,  32'hC0000002, 1'b0, 32'd0, 0);

        // Randomized run
        do_reset();
        exp_fetch = RPC;
        exp_valid = 1'b0;
        exp_drain = 1'b0;
        pend      = 1'b0;
        pend_pc   = 32'd0;
        exp_inst  = 32'd0;
        exp_next  = 32'd0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            clear_inputs();
            chk("r_req", mem_req, !exp_valid && !exp_drain);
            chk("r_vld", inst_valid, exp_valid);
            chk("r_err", fetch_err, 1'b0);
            if (!exp_valid && !exp_drain) chk("r_addr", mem_addr, exp_fetch);
            if (exp_valid) begin
                chk("r_inst", inst, exp_inst);
                chk("r_npc", next_pc, exp_next);
            end
            do_exc = ($urandom_range(0, 19) == 0);
            do_ack = ($urandom_range(0, 2) == 0);
            r = $urandom();
            p = $urandom();
            p[1:0] = 2'b00;
            mem_rdata = r;
            if (exp_drain) begin
                if (do_ack) begin
                    mem_ack   = 1'b1;
                    exp_drain = 1'b0;
                end else if (do_exc) begin
                    exc_en    = 1'b1;
                    exc_pc    = p;
                    exp_fetch = p;
                end
            end else if (exp_valid) begin
                is_jump = $urandom_range(0, 1) == 1;
                jump_pc = $urandom();
                jump_pc[1:0] = 2'b00;
                id_ready = $urandom_range(0, 1) == 1;
                if (do_exc) begin
                    exc_en    = 1'b1;
                    exc_pc    = p;
                    exp_fetch = p;
                    exp_valid = 1'b0;
                    pend      = 1'b0;
                end else if (id_ready) begin
                    exp_valid = 1'b0;
                    if (is_jump) begin
                        pend    = 1'b1;
                        pend_pc = jump_pc;
                    end
                end
            end else begin
                mem_ack = do_ack;
                if (do_exc) begin
                    exc_en    = 1'b1;
                    exc_pc    = p;
                    exp_drain = !do_ack;
                    exp_fetch = p;
                    pend      = 1'b0;
                end else if (do_ack) begin
                    exp_inst  = r;
                    exp_next  = exp_fetch + 32'd4;
                    exp_fetch = pend ? pend_pc : exp_fetch + 32'd4;
                    pend      = 1'b0;
                    exp_valid = 1'b1;
                end
            end
        end

        @(negedge clk);
        clear_inputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hBFC00000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port id_ready, input, 1, decode accepts the presented instruction this cycle.
REQ-005 SHALL have port is_jump, input, 1, decode reports the presented instruction as a jump or branch; sampled only at handover.
REQ-006 SHALL have port jump_pc, input, 32, jump target; sampled only at handover.
REQ-007 SHALL have port exc_en, input, 1, exception redirect request.
REQ-008 SHALL have port exc_pc, input, 32, exception handler address.
REQ-009 SHALL have port mem_req, output, 1, instruction-bus read request.
REQ-010 SHALL have port mem_addr, output, 32, instruction-bus word address.
REQ-011 SHALL have port mem_ack, input, 1, bus read complete; mem_rdata valid in the same cycle.
REQ-012 SHALL have port mem_rdata, input, 32, fetched instruction word.
REQ-013 SHALL have port inst_valid, output, 1, inst and next_pc are valid for decode.
REQ-014 SHALL have port inst, output, 32, instruction presented to decode.
REQ-015 SHALL have port next_pc, output, 32, address of the presented instruction plus 4.
REQ-016 SHALL have port fetch_err, output, 1, misaligned fetch address detected.
REQ-017 SHALL have port err_addr, output, 32, the offending address.

Function
REQ-018 SHALL keep a fetch_pc register, a pending flag, a pending_pc register and a 2-bit FSM with states REQ, VALID, DRAIN and ERR.
REQ-019 In REQ with fetch_pc[1:0]==0: mem_req=1 and mem_addr=fetch_pc; mem_req=0 in all other states.
REQ-020 REQ with mem_ack: inst<=mem_rdata, next_pc<=fetch_pc+4, inst_valid<=1, go to VALID.
REQ-021 REQ with mem_ack, pending set: fetch_pc<=pending_pc and pending cleared.
REQ-022 REQ with mem_ack, pending clear: fetch_pc<=fetch_pc+4, modulo 2^32 (wraps silently).
REQ-023 Handover SHALL occur when inst_valid and id_ready are both 1; on handover, inst_valid<=0 and the FSM goes to REQ, so the next request is issued the cycle after handover.
REQ-024 On handover with is_jump=1: pending<=1 and pending_pc<=jump_pc.
REQ-025 The effect of REQ-021 to REQ-024: exactly one delay-slot instruction (jump address + 4) is fetched before the target.
REQ-026 A jump handed over while another is pending SHALL overwrite pending_pc (last wins).
REQ-027 VALID with id_ready=0: inst, next_pc and inst_valid SHALL stay unchanged (no bubble, no refetch).
REQ-028 REQ with fetch_pc[1:0]!=0: no request is issued; fetch_err<=1, err_addr<=fetch_pc, go to ERR.
REQ-029 ERR SHALL hold fetch_err=1 until exc_en.
REQ-030 exc_en in REQ with mem_ack=0 (request outstanding): go to DRAIN.
REQ-031 exc_en in any other state: go to REQ.
REQ-032 exc_en (any state) SHALL set fetch_pc<=exc_pc, clear pending, force inst_valid<=0 and clear fetch_err.
REQ-033 exc_en takes priority over handover, over is_jump and over a same-cycle mem_ack; the acked data is discarded.
REQ-034 DRAIN: mem_req=0; on mem_ack, discard the data and go to REQ.
REQ-035 exc_en during DRAIN SHALL update fetch_pc and stay in DRAIN.
REQ-036 Per-fetch latency is 1 cycle plus bus wait: the instruction becomes valid the cycle after mem_ack.

Reset
REQ-037 While rst_n=0, outputs SHALL be: fetch_pc=RESET_PC, state=REQ, pending=0, pending_pc=0, inst_valid=0, inst=0, next_pc=0, fetch_err=0, err_addr=0.
REQ-038 Reset mid-transaction SHALL abandon any outstanding request without waiting for mem_ack.
REQ-039 The first mem_req SHALL be asserted the first cycle after rst_n rises.

Verification
REQ-040 Reset then zero-wait bus, id_ready=1 -> mem_addr sequence BFC00000, BFC00004, BFC00008; next_pc=BFC00004 with the first inst.
REQ-041 Jump at BFC00000, is_jump=1, jump_pc=80000100 -> fetches BFC00004 (delay slot) then 80000100, 80000104.
REQ-042 id_ready=0 for 5 cycles with inst=0x24020001 -> inst stable, no mem_req; resumes fetch one cycle after release.
REQ-043 exc_en with exc_pc=80000180 while a request is outstanding (ack 3 cycles later) -> data discarded, inst_valid stays 0, next mem_addr=80000180.
REQ-044 Jump to 80000102 -> fetch_err=1, err_addr=80000102, no mem_req until exc_en.
REQ-045 Fetch at FFFFFFFC -> next_pc=00000000, next mem_addr=00000000.
